// File: rtl/level_banner_pkg.sv
// Shared types, glyph codes and helpers for the "LEVEL nn" banner overlay.
package level_banner_pkg;

  localparam int unsigned GLYPH_W = 5;
  localparam int unsigned GLYPH_H = 7;

  localparam logic [5:0] GLY_L = 6'd21;
  localparam logic [5:0] GLY_E = 6'd14;
  localparam logic [5:0] GLY_V = 6'd31;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StShow
  } state_t;

  // 10^n, used for the BCD saturation threshold.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Glyph code of title cell k in "LEVEL".
  function automatic logic [5:0] title_code(input int unsigned k);
    logic [5:0] c;
    unique case (k)
      0, 4:    c = GLY_L;
      1, 3:    c = GLY_E;
      default: c = GLY_V;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/level_bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter, one shift per cycle.
// done_o pulses in the cycle of the final shift; bcd_o is valid alongside it.
module level_bcd_conv
  import level_banner_pkg::*;
#(
  parameter int unsigned LEVEL_W    = 8,
  parameter int unsigned NUM_DIGITS = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [LEVEL_W-1:0]      bin_i,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);

  localparam int unsigned     BcdW  = 4 * NUM_DIGITS;
  localparam int unsigned     CntW  = $clog2(LEVEL_W) + 1;
  localparam longint unsigned Limit = pow10(NUM_DIGITS);

  logic                busy_q;
  logic [CntW-1:0]     cnt_q;
  logic [LEVEL_W-1:0]  bin_q;
  logic [LEVEL_W-1:0]  sh_q;
  logic [BcdW-1:0]     bcd_q;
  logic [BcdW-1:0]     adj;
  logic [BcdW-1:0]     bcd_step;
  logic [LEVEL_W-1:0]  sh_step;
  logic                sat;

  // One add-3/shift step, plus saturation of the final result.
  always_comb begin
    adj = bcd_q;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
    end
    {bcd_step, sh_step} = {adj, sh_q} << 1;
    sat    = 64'(bin_q) >= Limit;
    done_o = busy_q && (cnt_q == CntW'(LEVEL_W - 1));
    bcd_o  = sat ? {NUM_DIGITS{4'd9}} : bcd_step;
  end

  // Conversion state: load on start, then shift LEVEL_W times.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      bin_q  <= '0;
      sh_q   <= '0;
      bcd_q  <= '0;
    end else if (!busy_q) begin
      if (start_i) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
        bin_q  <= bin_i;
        sh_q   <= bin_i;
        bcd_q  <= '0;
      end
    end else begin
      bcd_q <= bcd_step;
      sh_q  <= sh_step;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/level_banner_pixel.sv
// "LEVEL nn" overlay: banner FSM, frame counter with blinking number,
// region decode and a fixed 3-cycle glyph-ROM lookup pipeline.
module level_banner_pixel
  import level_banner_pkg::*;
#(
  parameter int unsigned LEVEL_W     = 8,
  parameter int unsigned NUM_DIGITS  = 2,
  parameter int unsigned SCALE_SHIFT = 4,
  parameter int unsigned TITLE_X     = 120,
  parameter int unsigned TITLE_Y     = 28,
  parameter int unsigned NUM_X       = 240,
  parameter int unsigned NUM_Y       = 160,
  parameter int unsigned SHOW_FRAMES = 120,
  parameter int unsigned BLINK_SHIFT = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               level_load_i,
  input  logic [LEVEL_W-1:0] level_i,
  input  logic               frame_start_i,
  input  logic [9:0]         h_cnt_i,
  input  logic [9:0]         v_cnt_i,
  output logic [5:0]         glyph_addr_o,
  output logic [2:0]         glyph_col_o,
  output logic [2:0]         glyph_row_o,
  input  logic [11:0]        glyph_pixel_i,
  output logic [11:0]        pixel_out_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               active_o
);

  localparam int unsigned CellW = GLYPH_W << SCALE_SHIFT;
  localparam int unsigned CellH = GLYPH_H << SCALE_SHIFT;
  // Wide enough for SHOW_FRAMES-1 and for the blink bit.
  localparam int unsigned FcW   = ($clog2(SHOW_FRAMES) > BLINK_SHIFT) ?
                                  $clog2(SHOW_FRAMES) : BLINK_SHIFT + 1;

  state_t                  state_q, state_d;
  logic [FcW-1:0]          frame_cnt_q, frame_cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic                    conv_start;
  logic                    conv_done;
  logic [4*NUM_DIGITS-1:0] conv_bcd;

  level_bcd_conv #(
    .LEVEL_W   (LEVEL_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_bcd (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(conv_start),
    .bin_i  (level_i),
    .done_o (conv_done),
    .bcd_o  (conv_bcd)
  );

  // Banner FSM next state; a load in SHOW beats the final frame_start.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    conv_start  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (level_load_i) begin
          conv_start = 1'b1;
          state_d    = StConvert;
        end
      end
      StConvert: begin
        if (conv_done) begin
          state_d     = StShow;
          frame_cnt_d = '0;
        end
      end
      StShow: begin
        if (level_load_i) begin
          conv_start = 1'b1;
          state_d    = StConvert;
        end else if (frame_start_i) begin
          if (frame_cnt_q == FcW'(SHOW_FRAMES - 1)) state_d = StIdle;
          else frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, frame counter and committed digits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      frame_cnt_q <= '0;
      digits_q    <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      if (conv_done) digits_q <= conv_bcd;
    end
  end

  assign busy_o   = (state_q == StConvert);
  assign active_o = (state_q == StShow);

  int unsigned hx, vy, cx;
  logic        dec_hit, dec_title;
  logic [5:0]  dec_addr;
  logic [2:0]  dec_col, dec_row;

  // Region decode; title is evaluated last so it wins on overlap.
  always_comb begin
    hx        = {22'd0, h_cnt_i};
    vy        = {22'd0, v_cnt_i};
    cx        = 0;
    dec_hit   = 1'b0;
    dec_title = 1'b0;
    dec_addr  = '0;
    dec_col   = '0;
    dec_row   = '0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      cx = NUM_X + d * CellW;
      if (hx >= cx && hx < cx + CellW && vy >= NUM_Y && vy < NUM_Y + CellH) begin
        dec_hit  = 1'b1;
        dec_addr = {2'b00, digits_q[4*(NUM_DIGITS-1-d) +: 4]};
        dec_col  = 3'((hx - cx) >> SCALE_SHIFT);
        dec_row  = 3'((vy - NUM_Y) >> SCALE_SHIFT);
      end
    end
    for (int unsigned k = 0; k < 5; k++) begin
      cx = TITLE_X + k * CellW;
      if (hx >= cx && hx < cx + CellW && vy >= TITLE_Y && vy < TITLE_Y + CellH) begin
        dec_hit   = 1'b1;
        dec_title = 1'b1;
        dec_addr  = title_code(k);
        dec_col   = 3'((hx - cx) >> SCALE_SHIFT);
        dec_row   = 3'((vy - TITLE_Y) >> SCALE_SHIFT);
      end
    end
  end

  logic        hit1_q, show1_q, hit2_q, show2_q;
  logic [5:0]  addr_q;
  logic [2:0]  col_q, row_q;
  logic        valid_q;
  logic [11:0] pixel_q;

  // Lookup pipeline: address stage, ROM-wait stage, output stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      hit1_q  <= 1'b0;
      show1_q <= 1'b0;
      hit2_q  <= 1'b0;
      show2_q <= 1'b0;
      valid_q <= 1'b0;
      pixel_q <= '0;
    end else begin
      addr_q  <= dec_addr;
      col_q   <= dec_col;
      row_q   <= dec_row;
      hit1_q  <= dec_hit & (state_q == StShow);
      show1_q <= dec_title | ~frame_cnt_q[BLINK_SHIFT];
      hit2_q  <= hit1_q;
      show2_q <= show1_q;
      valid_q <= hit2_q & show2_q;
      pixel_q <= (hit2_q & show2_q) ? glyph_pixel_i : 12'd0;
    end
  end

  assign glyph_addr_o = addr_q;
  assign glyph_col_o  = col_q;
  assign glyph_row_o  = row_q;
  assign valid_o      = valid_q;
  assign pixel_out_o  = pixel_q;

endmodule

// File: tb/tb_level_banner_pixel.sv
// Bench for level_banner_pixel: behavioural model + per-cycle compare,
// directed literal checks and a randomized phase.
module tb_level_banner_pixel;

  localparam int LW = 8, ND = 2, SS = 4, TX = 120, TY = 28, NX = 240, NY = 160;
  localparam int SF = 120, BS = 4, CW = 80, CH = 112;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        level_load = 1'b0;
  logic [7:0]  level = '0;
  logic        frame_start = 1'b0;
  logic [9:0]  h_cnt = '0, v_cnt = '0;
  logic [5:0]  glyph_addr;
  logic [2:0]  glyph_col, glyph_row;
  logic [11:0] glyph_pixel = '0;
  logic [11:0] pixel_out;
  logic        valid, busy, active;

  always #5 clk = ~clk;

  level_banner_pixel dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .level_load_i (level_load),
    .level_i      (level),
    .frame_start_i(frame_start),
    .h_cnt_i      (h_cnt),
    .v_cnt_i      (v_cnt),
    .glyph_addr_o (glyph_addr),
    .glyph_col_o  (glyph_col),
    .glyph_row_o  (glyph_row),
    .glyph_pixel_i(glyph_pixel),
    .pixel_out_o  (pixel_out),
    .valid_o      (valid),
    .busy_o       (busy),
    .active_o     (active)
  );

  function automatic logic [11:0] rom(input logic [5:0] a, input logic [2:0] c,
                                      input logic [2:0] r);
    return {a, c, r} ^ 12'hA5C;
  endfunction

  // Glyph ROM with one cycle of read latency.
  always @(posedge clk) glyph_pixel <= rom(glyph_addr, glyph_col, glyph_row);

  int n_chk = 0, n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Model state: 0 idle, 1 converting, 2 showing.
  int          m_mode = 0, m_left = 0, m_pend = 0, m_value = 0, m_frames = 0;
  logic [5:0]  m_s1_addr = '0;
  logic [2:0]  m_s1_col = '0, m_s1_row = '0;
  logic        m_s1_en = 1'b0, m_s2_en = 1'b0, m_valid = 1'b0;
  logic [11:0] m_s2_rom = '0, m_pix = '0;
  int          codes[5] = '{21, 14, 31, 14, 21};

  function automatic int digit_of(input int value, input int d);
    int p = 1;
    for (int i = 0; i < ND - 1 - d; i++) p = p * 10;
    return (value / p) % 10;
  endfunction

  function automatic int saturate(input int value);
    int lim = 1;
    for (int i = 0; i < ND; i++) lim = lim * 10;
    return (value >= lim) ? lim - 1 : value;
  endfunction

  task automatic decode(input int h, input int v, output logic hit, output logic title,
                        output logic [5:0] addr, output logic [2:0] col, output logic [2:0] row);
    int d;
    hit = 0; title = 0; addr = 0; col = 0; row = 0;
    if (h >= NX && h < NX + ND * CW && v >= NY && v < NY + CH) begin
      d = (h - NX) / CW;
      hit = 1;
      addr = 6'(digit_of(m_value, d));
      col = 3'(((h - NX) % CW) >> SS);
      row = 3'((v - NY) >> SS);
    end
    if (h >= TX && h < TX + 5 * CW && v >= TY && v < TY + CH) begin
      d = (h - TX) / CW;
      hit = 1;
      title = 1;
      addr = 6'(codes[d]);
      col = 3'(((h - TX) % CW) >> SS);
      row = 3'((v - TY) >> SS);
    end
  endtask

  // Reference model, advanced on every clock edge.
  always @(posedge clk) begin
    logic hit, title;
    logic [5:0] a;
    logic [2:0] c, r;
    if (rst) begin
      m_mode = 0; m_left = 0; m_value = 0; m_frames = 0;
      m_s1_addr = 0; m_s1_col = 0; m_s1_row = 0; m_s1_en = 0;
      m_s2_en = 0; m_s2_rom = 0; m_valid = 0; m_pix = 0;
    end else begin
      m_valid  = m_s2_en;
      m_pix    = m_s2_en ? m_s2_rom : 12'd0;
      m_s2_en  = m_s1_en;
      m_s2_rom = rom(m_s1_addr, m_s1_col, m_s1_row);
      decode(int'(h_cnt), int'(v_cnt), hit, title, a, c, r);
      m_s1_addr = a; m_s1_col = c; m_s1_row = r;
      m_s1_en = hit && (m_mode == 2) && (title || ((m_frames >> BS) & 1) == 0);
      case (m_mode)
        0: if (level_load) begin m_mode = 1; m_left = LW; m_pend = int'(level); end
        1: begin
          m_left--;
          if (m_left == 0) begin m_value = saturate(m_pend); m_mode = 2; m_frames = 0; end
        end
        default: begin
          if (level_load) begin m_mode = 1; m_left = LW; m_pend = int'(level); end
          else if (frame_start) begin
            if (m_frames == SF - 1) m_mode = 0;
            else m_frames++;
          end
        end
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("glyph_addr", glyph_addr, m_s1_addr);
      chk("glyph_col", glyph_col, m_s1_col);
      chk("glyph_row", glyph_row, m_s1_row);
      chk("valid", valid, m_valid);
      chk("pixel_out", pixel_out, m_pix);
      chk("busy", busy, m_mode == 1);
      chk("active", active, m_mode == 2);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input int lv);
    level = 8'(lv); level_load = 1; tick(); level_load = 0;
  endtask

  task automatic pulses(input int n);
    repeat (n) begin frame_start = 1; tick(); frame_start = 0; tick(); end
  endtask

  int hlist[10] = '{119, 120, 199, 200, 519, 520, 239, 240, 399, 400};
  int vlist[8]  = '{27, 28, 139, 140, 159, 160, 271, 272};

  initial begin
    // 1: reset
    h_cnt = 240; v_cnt = 160;
    tick(2);
    cmp_en = 1;
    chk("rst_valid", valid, 0);
    chk("rst_pixel", pixel_out, 0);
    chk("rst_active", active, 0);
    chk("rst_addr", glyph_addr, 0);
    rst = 0;
    tick(3);
    chk("idle_valid", valid, 0);

    // 2: level 7, 8 busy cycles then active
    load(7);
    for (int i = 0; i < 8; i++) begin
      chk("conv_busy", busy, 1);
      chk("conv_active", active, 0);
      tick();
    end
    chk("show_active", active, 1);
    chk("show_busy", busy, 0);
    tick();
    chk("num0_addr", glyph_addr, 0);
    chk("num0_col", glyph_col, 0);
    chk("num0_row", glyph_row, 0);
    tick(2);
    chk("num0_valid", valid, 1);
    chk("num0_pixel", pixel_out, 12'hA5C);
    h_cnt = 320; tick();
    chk("num1_addr", glyph_addr, 7);

    // 3: title
    h_cnt = 215; v_cnt = 59; tick();
    chk("title_e_addr", glyph_addr, 14);
    chk("title_e_col", glyph_col, 0);
    chk("title_e_row", glyph_row, 1);
    h_cnt = 199; tick();
    chk("title_l_addr", glyph_addr, 21);
    chk("title_l_col", glyph_col, 4);
    tick(2);
    chk("title_l_pixel", pixel_out, 12'hF3D);
    h_cnt = 520; tick(3);
    chk("title_edge_valid", valid, 0);

    // 4: saturation, load during convert ignored, old digits held
    h_cnt = 320; v_cnt = 160;
    load(150);
    tick(2);
    level = 3; level_load = 1; tick(); level_load = 0;
    chk("old_digit", glyph_addr, 7);
    tick(5);
    chk("sat_active", active, 1);
    tick();
    chk("sat_units", glyph_addr, 9);
    h_cnt = 240; tick();
    chk("sat_tens", glyph_addr, 9);

    // 5: frame counting and blink
    pulses(16);
    tick(3);
    chk("blink_num_off", valid, 0);
    h_cnt = 215; v_cnt = 59; tick(3);
    chk("blink_title_on", valid, 1);
    pulses(16);
    h_cnt = 240; v_cnt = 160; tick(3);
    chk("blink_num_on", valid, 1);
    pulses(87);
    chk("before_last_active", active, 1);
    frame_start = 1; tick(); frame_start = 0;
    chk("after_last_active", active, 0);
    load(42);
    tick(8);
    chk("reshow_active", active, 1);
    pulses(119);
    frame_start = 1; level = 5; level_load = 1; tick();
    frame_start = 0; level_load = 0;
    chk("coinc_busy", busy, 1);
    chk("coinc_active", active, 0);
    tick(8);
    chk("coinc_active2", active, 1);
    tick();
    chk("coinc_digit", glyph_addr, 0);

    // 6: reset mid-convert and mid-show
    load(12);
    tick(2);
    rst = 1; tick(); rst = 0;
    chk("rst_conv_busy", busy, 0);
    load(33);
    tick(8);
    h_cnt = 215; v_cnt = 59; tick(3);
    chk("pre_rst_valid", valid, 1);
    rst = 1; tick(); rst = 0;
    chk("rst_show_active", active, 0);
    chk("rst_show_valid", valid, 0);
    chk("rst_show_addr", glyph_addr, 0);

    // Randomized phase
    for (int i = 0; i < 6000; i++) begin
      rst         = ($urandom % 900) == 0;
      level_load  = ($urandom % 250) == 0;
      level       = 8'($urandom);
      frame_start = ($urandom % 4) == 0;
      h_cnt = ($urandom % 2) ? 10'(hlist[$urandom % 10]) : 10'($urandom % 640);
      v_cnt = ($urandom % 2) ? 10'(vlist[$urandom % 8]) : 10'($urandom % 480);
      tick();
    end
    rst = 0; level_load = 0; frame_start = 0;
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
